// File: rtl/tdm_demux_if.sv
// Bus bundle for tdm_demux. Groups the slot input and frame output so both
// sides share one width-parameterised definition.
//   slave  : demux side  (enable, din, fsync in; dout, valid, locked, sync_err, parity_err out)
//   master : source/sink side (opposite directions)
interface tdm_demux_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 4
);
    logic                      enable;
    logic [WIDTH-1:0]          din;
    logic                      fsync;
    logic [CHANNELS*WIDTH-1:0] dout;
    logic                      valid;
    logic                      locked;
    logic                      sync_err;
    logic                      parity_err;

    modport master (
        output enable, din, fsync,
        input  dout, valid, locked, sync_err, parity_err
    );

    modport slave (
        input  enable, din, fsync,
        output dout, valid, locked, sync_err, parity_err
    );
endinterface

// File: rtl/tdm_demux.sv
// TDM frame demultiplexer. Collects CHANNELS slot words per frame (frame start
// marked by fsync) into a shadow register and publishes the complete frame on
// dout with a one-cycle valid pulse. Framing violations pulse sync_err.
// Optional macro TDM_DEMUX_PARITY_EN adds a trailing XOR parity slot per frame;
// a mismatch pulses parity_err and withholds the frame. Without it parity_err
// is tied to 0.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset (overrides enable)
//   bus   : tdm_demux_if.slave (enable, din, fsync in; dout, valid, locked,
//           sync_err, parity_err out; channel k at dout[k*WIDTH +: WIDTH])
module tdm_demux #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 4
) (
    input  logic       clock,
    input  logic       reset,
    tdm_demux_if.slave bus
);

    localparam int unsigned FRAME_W = CHANNELS * WIDTH;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned SLOTS   = CHANNELS + 1;
`else
    localparam int unsigned SLOTS   = CHANNELS;
`endif
    localparam int unsigned CNT_W   = $clog2(SLOTS);
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);
`ifdef TDM_DEMUX_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_SLOT = CNT_W'(CHANNELS);
`endif

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_W-1:0] shadow_q;
    logic [FRAME_W-1:0] dout_q;
    logic               valid_q;
    logic               locked_q;
    logic               sync_err_q;
    logic [FRAME_W-1:0] frame_d;
`ifdef TDM_DEMUX_PARITY_EN
    logic               parity_err_q;
    logic [WIDTH-1:0]   parity_d;
`endif

    // Frame to publish: in the plain build the last channel comes straight
    // from din so dout updates on the same edge that samples it.
    always_comb begin
        frame_d = shadow_q;
`ifndef TDM_DEMUX_PARITY_EN
        frame_d[FRAME_W-1 -: WIDTH] = bus.din;
`endif
    end

`ifdef TDM_DEMUX_PARITY_EN
    // Expected parity slot: XOR of all stored channel words.
    always_comb begin
        parity_d = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            parity_d = parity_d ^ shadow_q[k*WIDTH +: WIDTH];
        end
    end
`endif

    // Framing FSM, slot counter, shadow and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            shadow_q   <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (bus.enable) begin
                unique case (state_q)
                    HUNT: begin
                        if (bus.fsync) begin
                            shadow_q[WIDTH-1:0] <= bus.din;
                            cnt_q               <= CNT_W'(1);
                            state_q             <= LOCKED;
                            locked_q            <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (bus.fsync) begin
                            // Early fsync restarts the frame; the stale partial
                            // shadow is overwritten before it can be published.
                            sync_err_q          <= (cnt_q != '0);
                            shadow_q[WIDTH-1:0] <= bus.din;
                            cnt_q               <= CNT_W'(1);
                        end else if (cnt_q == '0) begin
                            sync_err_q <= 1'b1;
                            state_q    <= HUNT;
                            locked_q   <= 1'b0;
                        end else if (cnt_q == LAST_CH) begin
`ifdef TDM_DEMUX_PARITY_EN
                            shadow_q[FRAME_W-1 -: WIDTH] <= bus.din;
                            cnt_q                        <= cnt_q + CNT_W'(1);
`else
                            dout_q  <= frame_d;
                            valid_q <= 1'b1;
                            cnt_q   <= '0;
`endif
                        end
`ifdef TDM_DEMUX_PARITY_EN
                        else if (cnt_q == PAR_SLOT) begin
                            if (bus.din == parity_d) begin
                                dout_q  <= frame_d;
                                valid_q <= 1'b1;
                            end else begin
                                parity_err_q <= 1'b1;
                            end
                            cnt_q <= '0;
                        end
`endif
                        else begin
                            for (int unsigned k = 1; k < CHANNELS - 1; k++) begin
                                if (cnt_q == CNT_W'(k)) begin
                                    shadow_q[k*WIDTH +: WIDTH] <= bus.din;
                                end
                            end
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign bus.dout     = dout_q;
    assign bus.valid    = valid_q;
    assign bus.locked   = locked_q;
    assign bus.sync_err = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed frames plus randomized slot
// traffic, compared each cycle against a queue-based frame model.
module tb_tdm_demux;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned FW = CH * W;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned SLOTS = CH + 1;
    localparam bit          PAR   = 1'b1;
`else
    localparam int unsigned SLOTS = CH;
    localparam bit          PAR   = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdm_demux_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_valid = 0;

    // Reference model: frame in progress is simply the list of words received.
    bit             m_locked;
    logic [W-1:0]   m_q[$];
    logic [FW-1:0]  m_dout;
    bit             m_valid, m_serr, m_perr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit en, input bit fs, input logic [W-1:0] d);
        logic [FW-1:0] frame;
        logic [W-1:0]  x;
        m_valid = 0;
        m_serr  = 0;
        m_perr  = 0;
        if (r) begin
            m_locked = 0;
            m_q.delete();
            m_dout = '0;
        end else if (en) begin
            if (!m_locked) begin
                if (fs) begin
                    m_q.delete();
                    m_q.push_back(d);
                    m_locked = 1;
                end
            end else if (fs) begin
                if (m_q.size() != 0) m_serr = 1;
                m_q.delete();
                m_q.push_back(d);
            end else if (m_q.size() == 0) begin
                m_serr   = 1;
                m_locked = 0;
            end else begin
                m_q.push_back(d);
                if (m_q.size() == SLOTS) begin
                    frame = '0;
                    x     = '0;
                    for (int k = 0; k < CH; k++) begin
                        frame = frame | (FW'(m_q[k]) << (k * W));
                        x     = x ^ m_q[k];
                    end
                    if (PAR && (m_q[SLOTS-1] != x)) begin
                        m_perr = 1;
                    end else begin
                        m_dout  = frame;
                        m_valid = 1;
                    end
                    m_q.delete();
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, compare 1 time unit after rising edge.
    task automatic step(input bit en, input bit fs, input logic [W-1:0] d, input bit r);
        @(negedge clk);
        rst        = r;
        bus.enable = en;
        bus.fsync  = fs;
        bus.din    = d;
        model_edge(r, en, fs, d);
        @(posedge clk);
        #1;
        check_eq("dout",       64'(bus.dout),       64'(m_dout));
        check_eq("valid",      64'(bus.valid),      64'(m_valid));
        check_eq("locked",     64'(bus.locked),     64'(m_locked));
        check_eq("sync_err",   64'(bus.sync_err),   64'(m_serr));
        check_eq("parity_err", 64'(bus.parity_err), 64'(m_perr));
        if (bus.valid) n_valid++;
    endtask

    // Send one aligned frame; channel k taken from f[k*W +: W], parity appended when enabled.
    task automatic send_frame(input logic [FW-1:0] f, input bit bad_par);
        logic [W-1:0] x;
        x = '0;
        for (int k = 0; k < CH; k++) begin
            step(1'b1, (k == 0), f[k*W +: W], 1'b0);
            x = x ^ f[k*W +: W];
        end
        if (PAR) step(1'b1, 1'b0, bad_par ? ~x : x, 1'b0);
    endtask

    initial begin
        int           pos;
        logic [W-1:0] acc;
        int           v0;
        logic [FW-1:0] f;

        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.fsync  = 1'b0;
        bus.din    = '0;

        // Reset state, with enable high to confirm reset wins.
        step(1'b1, 1'b1, 4'hF, 1'b1);
        check_eq("rst_dout", 64'(bus.dout), 64'h0);

        // Single frame 1,2,3,4.
        v0 = n_valid;
        send_frame(16'h4321, 1'b0);
        check_eq("frame_4321", 64'(bus.dout), 64'h4321);
        check_eq("one_valid", 64'(n_valid - v0), 64'd1);

        // Back-to-back frames.
        send_frame(16'hDCBA, 1'b0);
        check_eq("frame_dcba", 64'(bus.dout), 64'hDCBA);
        send_frame(16'h8765, 1'b0);
        check_eq("frame_8765", 64'(bus.dout), 64'h8765);

        // Early fsync at counter 2, then a full frame of 9s.
        step(1'b1, 1'b1, 4'h1, 1'b0);
        step(1'b1, 1'b0, 4'h2, 1'b0);
        send_frame(16'h9999, 1'b0);
        check_eq("resync_9999", 64'(bus.dout), 64'h9999);

        // Missing fsync at frame start drops lock; garbage ignored while hunting.
        step(1'b1, 1'b0, 4'h5, 1'b0);
        check_eq("unlock", 64'(bus.locked), 64'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, W'($urandom), 1'b0);
        check_eq("hunt_hold", 64'(bus.dout), 64'h9999);

        // Enable toggling across a frame.
        f = 16'hA5C3;
        for (int k = 0; k < SLOTS; k++) begin
            logic [W-1:0] w;
            w = (k < CH) ? f[k*W +: W] : (4'h3 ^ 4'hC ^ 4'h5 ^ 4'hA);
            step(1'b1, (k == 0), w, 1'b0);
            step(1'b0, $urandom_range(0, 1) == 1, W'($urandom), 1'b0);
        end
        check_eq("gapped_a5c3", 64'(bus.dout), 64'hA5C3);

        // Bad parity withholds the frame (no-op frame in the plain build).
        send_frame(16'h1111, 1'b1);
        if (PAR) check_eq("par_hold", 64'(bus.dout), 64'hA5C3);

        // Reset mid-frame discards the partial frame.
        step(1'b1, 1'b1, 4'h7, 1'b0);
        step(1'b1, 1'b0, 4'h7, 1'b0);
        step(1'b1, 1'b0, 4'h7, 1'b1);
        check_eq("midrst_dout", 64'(bus.dout), 64'h0);
        step(1'b1, 1'b0, 4'h7, 1'b0);

        // Randomized traffic: mostly well-formed frames with injected faults.
        pos = 0;
        acc = '0;
        for (int i = 0; i < 3000; i++) begin
            bit           r, en, fs;
            logic [W-1:0] d;
            r  = ($urandom_range(0, 399) == 0);
            en = ($urandom_range(0, 3) != 0);
            d  = W'($urandom);
            fs = (pos == 0);
            if ($urandom_range(0, 29) == 0) fs = ~fs;
            if (PAR && (pos == CH)) begin
                d = acc;
                if ($urandom_range(0, 4) == 0) d = ~acc;
            end
            step(en, fs, d, r);
            if (en && !r) begin
                if (pos == 0) acc = d;
                else if (pos < CH) acc = acc ^ d;
                pos = (pos + 1) % SLOTS;
            end
        end
        check_eq("valid_seen", 64'(n_valid > 50), 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4: slots per frame, range 2..16.
REQ-002 The block SHALL have parameter WIDTH, default 4: bits per slot word, range 1..16.
REQ-003 The block SHALL have port clock  input  1  rising-edge system clock.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port enable  input  1  slot strobe; sampling occurs only on edges where enable=1.
REQ-006 The block SHALL have port din  input  WIDTH  time-multiplexed slot word.
REQ-007 The block SHALL have port fsync  input  1  frame marker; high together with the slot-0 word.
REQ-008 The block SHALL have port dout  output  CHANNELS*WIDTH  demultiplexed frame; channel k in dout[k*WIDTH +: WIDTH].
REQ-009 The block SHALL have port valid  output  1  one-cycle pulse on each dout update.
REQ-010 The block SHALL have port locked  output  1  high while in state LOCKED.
REQ-011 The block SHALL have port sync_err  output  1  one-cycle pulse on a framing violation.
REQ-012 The block SHALL have port parity_err  output  1  one-cycle pulse on a parity failure (see Configuration).

Function
REQ-013 The block SHALL implement two states, HUNT and LOCKED, plus a slot counter and a CHANNELS*WIDTH shadow register.
REQ-014 The block SHALL hold all state and outputs unchanged on edges with enable=0, except that valid, sync_err and parity_err SHALL return to 0.
REQ-015 In HUNT, an enabled edge with fsync=1 SHALL write din to shadow slot 0, set the counter to 1 and enter LOCKED; with fsync=0, din SHALL be ignored.
REQ-016 In LOCKED, an enabled edge at counter=s (0<s<last) with fsync=0 SHALL write din to shadow slot s and increment the counter.
REQ-017 In LOCKED, fsync=1 at counter≠0 SHALL pulse sync_err, discard the partial frame, write din to shadow slot 0, set the counter to 1 and stay in LOCKED.
REQ-018 In LOCKED, fsync=0 at counter=0 SHALL pulse sync_err, discard din and return to HUNT.
REQ-019 On the enabled edge that samples the last channel slot, dout SHALL load the shadow contents with din placed in channel CHANNELS-1, valid SHALL pulse, and the counter SHALL wrap to 0 (latency: dout and valid visible one cycle after the last slot is presented).
REQ-020 dout SHALL change only atomically on valid edges; it SHALL never expose a partial frame.
REQ-021 A frame whose fsync arrives exactly at counter=0 SHALL continue without a gap; back-to-back frames SHALL produce a valid pulse every CHANNELS enabled edges (CHANNELS+1 with parity).

Reset
REQ-022 On an edge with reset=1, the block SHALL enter HUNT, zero the counter and shadow, and drive dout=0, valid=0, locked=0, sync_err=0 and parity_err=0; reset SHALL override enable.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame without a valid pulse.

Configuration
REQ-024 With macro TDM_DEMUX_PARITY_EN defined, each frame SHALL carry one extra slot after channel CHANNELS-1 containing the bitwise XOR of all channel words.
REQ-025 With TDM_DEMUX_PARITY_EN defined, the block SHALL check the parity slot on its sampling edge: on a match, dout SHALL load and valid SHALL pulse; on a mismatch, parity_err SHALL pulse, dout SHALL be held and valid SHALL stay 0; in either case the block SHALL stay in LOCKED.
REQ-026 Without TDM_DEMUX_PARITY_EN, the frame SHALL be CHANNELS slots, REQ-019 SHALL apply, and parity_err SHALL be tied to 0.

Verification (defaults, macro undefined unless stated)
REQ-027 Reset, then enable=1, fsync=1 with din 1,2,3,4 on consecutive edges -> dout=16'h4321, valid high exactly one cycle, locked=1 from the second cycle.
REQ-028 Two back-to-back frames A,B,C,D then 5,6,7,8 -> valid pulses 4 cycles apart, dout=16'hDCBA then 16'h8765, sync_err stays 0.
REQ-029 Locked, fsync=1 at counter=2 -> sync_err pulses once, no valid, the next 4 slots 9,9,9,9 -> dout=16'h9999.
REQ-030 Locked, fsync=0 at an expected frame start -> sync_err pulses, locked=0, no dout change until the next fsync.
REQ-031 enable toggling 1,0,1,0 across a frame -> dout identical to the continuous-enable result, valid delayed by the idle edges.
REQ-032 Macro defined, frame 1,2,3,4 with parity 4 -> valid, dout=16'h4321; parity 5 -> parity_err pulses, dout held.
